bcd_stopwatch: RTL

Parametrised multi-digit BCD stopwatch/timer for the DE-series lab boards, driving one 7-segment display per digit. It divides CLOCK_50 down to a count tick, counts up or down in decimal with a ripple carry/borrow, and adds run/stop, lap-freeze, preload and end-of-range handling (wrap or saturate-and-stop). It sits directly under the board top level, fed by debounced single-cycle key/switch pulses, with its HEX outputs wired to HEX0..HEX(DIGITS-1).

---
 rtl/bcd_stopwatch.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/bcd_stopwatch.sv
// bcd_stopwatch: multi-digit decimal stopwatch/timer with 7-segment outputs.
// Divides the system clock down to a count tick, counts up or down in BCD
// with full ripple carry/borrow per tick, and supports run/stop, lap-freeze,
// preload and end-of-range wrap or saturate-and-stop.
//
// Ports:
//   CLOCK_50    in   system clock
//   RESET       in   synchronous active-high reset
//   START_STOP  in   single-cycle pulse, toggles run/stop
//   LAP         in   single-cycle pulse, toggles display freeze
//   DOWN        in   count direction level (1 = down)
//   LOAD        in   single-cycle pulse, preload counter from LOAD_VAL
//   LOAD_VAL    in   BCD preload value, digit i at [4i+3:4i]
//   COUNT       out  live BCD count (registered)
//   HEX         out  active-low segments {g..a}, digit i at [7i+6:7i]
//   RUNNING     out  high while running
//   LAP_ACTIVE  out  high while the display is frozen
//   WRAP        out  one-cycle pulse on end-of-range tick
module bcd_stopwatch #(
  parameter int unsigned DIGITS   = 3,
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned SATURATE = 0
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET,
  input  logic                  START_STOP,
  input  logic                  LAP,
  input  logic                  DOWN,
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   LOAD_VAL,
  output logic [4*DIGITS-1:0]   COUNT,
  output logic [7*DIGITS-1:0]   HEX,
  output logic                  RUNNING,
  output logic                  LAP_ACTIVE,
  output logic                  WRAP
);

  localparam int unsigned CW = 4 * DIGITS;
  localparam int unsigned PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  typedef enum logic {ST_STOP, ST_RUN} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   lap_q, lap_d;
  logic            lap_active_q, lap_active_d;
  logic            wrap_q, wrap_d;

  logic [CW-1:0]   cnt_up_c, cnt_dn_c, load_clamp_c, display_c;
  logic            all9_c, all0_c, tick_c;

  // Ripple increment/decrement; the final carry/borrow flags the range end
  // and the rippled value is already the wrapped result (000 / 999).
  always_comb begin
    logic       carry, borrow;
    logic [3:0] d;
    carry    = 1'b1;
    borrow   = 1'b1;
    cnt_up_c = count_q;
    cnt_dn_c = count_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      d = count_q[4*i +: 4];
      if (carry) begin
        if (d == 4'd9) begin
          cnt_up_c[4*i +: 4] = 4'd0;
        end else begin
          cnt_up_c[4*i +: 4] = d + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (d == 4'd0) begin
          cnt_dn_c[4*i +: 4] = 4'd9;
        end else begin
          cnt_dn_c[4*i +: 4] = d - 4'd1;
          borrow = 1'b0;
        end
      end
    end
    all9_c = carry;
    all0_c = borrow;
  end

  // Preload value with non-decimal digits clamped to 9.
  always_comb begin
    logic [3:0] d;
    load_clamp_c = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      d = LOAD_VAL[4*i +: 4];
      load_clamp_c[4*i +: 4] = (d > 4'd9) ? 4'd9 : d;
    end
  end

  assign tick_c = (state_q == ST_RUN) && (presc_q == PRESC_MAX);

  // Next-state: LOAD beats START_STOP beats tick; LAP is handled alongside.
  always_comb begin
    state_d      = state_q;
    presc_d      = presc_q;
    count_d      = count_q;
    lap_d        = lap_q;
    lap_active_d = lap_active_q;
    wrap_d       = 1'b0;

    if (LAP) begin
      lap_active_d = ~lap_active_q;
      if (!lap_active_q) lap_d = count_q;
    end

    if (LOAD) begin
      count_d = load_clamp_c;
      presc_d = '0;
    end else begin
      if (state_q == ST_RUN) presc_d = tick_c ? '0 : presc_q + PW'(1);
      if (tick_c) begin
        if (DOWN) begin
          if (all0_c) begin
            wrap_d = 1'b1;
            if (SATURATE != 0) state_d = ST_STOP;
            else               count_d = cnt_dn_c;
          end else begin
            count_d = cnt_dn_c;
          end
        end else begin
          if (all9_c) begin
            wrap_d = 1'b1;
            if (SATURATE != 0) state_d = ST_STOP;
            else               count_d = cnt_up_c;
          end else begin
            count_d = cnt_up_c;
          end
        end
      end
      if (START_STOP) state_d = (state_q == ST_RUN) ? ST_STOP : ST_RUN;
    end
  end

  // State registers.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q      <= ST_STOP;
      presc_q      <= '0;
      count_q      <= '0;
      lap_q        <= '0;
      lap_active_q <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      count_q      <= count_d;
      lap_q        <= lap_d;
      lap_active_q <= lap_active_d;
      wrap_q       <= wrap_d;
    end
  end

  assign COUNT      = count_q;
  assign RUNNING    = (state_q == ST_RUN);
  assign LAP_ACTIVE = lap_active_q;
  assign WRAP       = wrap_q;
  assign display_c  = lap_active_q ? lap_q : count_q;

  // Active-low {g..a} decode; non-decimal codes blank.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_hex
    assign HEX[7*g +: 7] = seg7(display_c[4*g +: 4]);
  end

endmodule
